handshake_ram: RTL and testbench

Parametrised single-port synchronous data memory for the MIPS pipeline with a req/ack handshake, per-byte write enables and a configurable number of wait states. It replaces the fixed 32x256 always-ready RAM. The instruction fetch stage or the memory stage can stall on `ack` exactly as it would on a slow external memory. Instruction and data memories are separate instances.

---
 rtl/handshake_ram.sv | 112 +++++++++++
 tb/tb_handshake_ram.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/handshake_ram.sv
// Single-port synchronous data memory with a req/ack handshake, per-byte write
// enables and a fixed number of wait states before each access completes.
module handshake_ram #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  input  logic                    wr_en_i,
  input  logic [DATA_WIDTH/8-1:0] byte_en_i,
  input  logic [ADDR_BITS-1:0]    addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    ack_o,
  output logic                    busy_o
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned Depth    = 1 << ADDR_BITS;

  typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    wr_q;
  logic [NumBytes-1:0]     be_q;
  logic [ADDR_BITS-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    latch_en;
  logic                    do_access;

  logic [DATA_WIDTH-1:0]   mem [Depth];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_en  = 1'b0;
    do_access = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_i) begin
          state_d  = StAccess;
          cnt_d    = 4'(WAIT_STATES);
          latch_en = 1'b1;
        end
      end
      StAccess: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          do_access = 1'b1;
          state_d   = StAck;
        end
      end
      StAck: begin
        // A request still held at the closing edge starts the next access.
        if (req_i) begin
          state_d  = StAccess;
          cnt_d    = 4'(WAIT_STATES);
          latch_en = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_en) begin
        wr_q    <= wr_en_i;
        be_q    <= byte_en_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      if (do_access && !wr_q) begin
        rdata_q <= mem[addr_q];
      end
    end
  end

  // Array is not reset; do_access is already low once reset forces StIdle.
  always_ff @(posedge clk_i) begin
    if (do_access && wr_q) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (be_q[i]) begin
          mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;
  assign ack_o   = (state_q == StAck);
  assign busy_o  = (state_q == StAccess);

endmodule

// File: tb/tb_handshake_ram.sv
// Directed bench for handshake_ram: instance 0 has no wait states, instance 1
// has three; a vector table plus hand-written reset and pipelining sequences.
module tb_handshake_ram;

  logic              clk;
  logic [1:0]        rst_n;
  logic [1:0]        req;
  logic [1:0]        wr_en;
  logic [1:0][3:0]   byte_en;
  logic [1:0][7:0]   addr;
  logic [1:0][31:0]  wdata;
  logic [1:0][31:0]  rdata;
  logic [1:0]        ack;
  logic [1:0]        busy;

  int total = 0;
  int bad   = 0;

  handshake_ram #(.DATA_WIDTH(32), .ADDR_BITS(8), .WAIT_STATES(0), .INIT_FILE("")) u_ram0 (
    .clk_i     (clk),
    .rst_ni    (rst_n[0]),
    .req_i     (req[0]),
    .wr_en_i   (wr_en[0]),
    .byte_en_i (byte_en[0]),
    .addr_i    (addr[0]),
    .wdata_i   (wdata[0]),
    .rdata_o   (rdata[0]),
    .ack_o     (ack[0]),
    .busy_o    (busy[0])
  );

  handshake_ram #(.DATA_WIDTH(32), .ADDR_BITS(8), .WAIT_STATES(3), .INIT_FILE("")) u_ram1 (
    .clk_i     (clk),
    .rst_ni    (rst_n[1]),
    .req_i     (req[1]),
    .wr_en_i   (wr_en[1]),
    .byte_en_i (byte_en[1]),
    .addr_i    (addr[1]),
    .wdata_i   (wdata[1]),
    .rdata_o   (rdata[1]),
    .ack_o     (ack[1]),
    .busy_o    (busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          d;
    bit          we;
    logic [3:0]  be;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_busy;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Issues one request, waits for ack (bounded), then drops req in the ACK cycle.
  task automatic do_op(input int d, input bit we, input logic [3:0] be, input logic [7:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output int lat,
                       output int bcyc);
    bit got;
    @(negedge clk);
    req[d] = 1'b1; wr_en[d] = we; byte_en[d] = be; addr[d] = a; wdata[d] = wd;
    lat = 0; bcyc = 0; got = 1'b0; rd = 'x;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (busy[d]) bcyc++;
      if (ack[d]) begin
        rd  = rdata[d];
        got = 1'b1;
      end
    end
    req[d] = 1'b0;
    if (!got) lat = -1;
    @(negedge clk);
    chk($sformatf("ack_pulse_d%0d", d), {31'd0, ack[d]}, 32'd0);
  endtask

  logic [31:0] rd;
  int          lat, bcyc, cyc, last, n;
  bit          seen;

  initial begin
    rst_n = 2'b00; req = 2'b11; wr_en = '0; byte_en = '0; addr = '0; wdata = '0;

    // Reset held with req high: nothing accepted, outputs at reset values.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("rst_ack_d%0d", d), {31'd0, ack[d]}, 32'd0);
        chk($sformatf("rst_busy_d%0d", d), {31'd0, busy[d]}, 32'd0);
      end
    end
    chk("rst_rdata_d0", rdata[0], 32'h0);
    chk("rst_rdata_d1", rdata[1], 32'h0);
    req = 2'b00;
    @(negedge clk);
    rst_n = 2'b11;

    vecs[0]  = '{0, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 32'h00000000, 2, 1};
    vecs[1]  = '{0, 1'b0, 4'h0, 8'h10, 32'h0,        32'hDEADBEEF, 2, 1};
    vecs[2]  = '{0, 1'b1, 4'h5, 8'h10, 32'h11223344, 32'hDEADBEEF, 2, 1};
    vecs[3]  = '{0, 1'b0, 4'hF, 8'h10, 32'h0,        32'hDE22BE44, 2, 1};
    vecs[4]  = '{0, 1'b1, 4'h0, 8'h10, 32'hFFFFFFFF, 32'hDE22BE44, 2, 1};
    vecs[5]  = '{0, 1'b0, 4'h0, 8'h10, 32'h0,        32'hDE22BE44, 2, 1};
    vecs[6]  = '{0, 1'b1, 4'hA, 8'h10, 32'h55667788, 32'hDE22BE44, 2, 1};
    vecs[7]  = '{0, 1'b0, 4'h0, 8'h10, 32'h0,        32'h5522773A, 2, 1};
    vecs[8]  = '{1, 1'b1, 4'hF, 8'h00, 32'h10000000, 32'h00000000, 5, 4};
    vecs[9]  = '{1, 1'b1, 4'hF, 8'h01, 32'h10000001, 32'h00000000, 5, 4};
    vecs[10] = '{1, 1'b1, 4'hF, 8'h02, 32'h10000002, 32'h00000000, 5, 4};
    vecs[11] = '{1, 1'b1, 4'hF, 8'h03, 32'h10000003, 32'h00000000, 5, 4};
    vecs[12] = '{1, 1'b1, 4'hF, 8'h20, 32'h00000000, 32'h00000000, 5, 4};
    vecs[13] = '{1, 1'b0, 4'hF, 8'h20, 32'h0,        32'h00000000, 5, 4};
    // vecs[7]: lanes 1,3 of 0x55667788 over 0xDE22BE44 -> 0x55_22_77_44.
    vecs[7].exp_rd = 32'h55227744;

    foreach (vecs[k]) begin
      do_op(vecs[k].d, vecs[k].we, vecs[k].be, vecs[k].a, vecs[k].wd, rd, lat, bcyc);
      chk($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rd);
      chk($sformatf("vec%0d_latency", k), lat, vecs[k].exp_lat);
      chk($sformatf("vec%0d_busy", k), bcyc, vecs[k].exp_busy);
    end

    // Address change while in ACCESS must not affect the read.
    @(negedge clk);
    req[1] = 1'b1; wr_en[1] = 1'b0; addr[1] = 8'h01; byte_en[1] = 4'h0;
    @(negedge clk);
    chk("hold_busy", {31'd0, busy[1]}, 32'd1);
    addr[1] = 8'h02; wr_en[1] = 1'b1; wdata[1] = 32'hFFFFFFFF; byte_en[1] = 4'hF;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ack[1]) begin
        seen = 1'b1;
        chk("hold_rdata", rdata[1], 32'h10000001);
      end
    end
    req[1] = 1'b0;
    chk("hold_ack_seen", {31'd0, seen}, 32'd1);
    do_op(1, 1'b0, 4'h0, 8'h02, 32'h0, rd, lat, bcyc);
    chk("hold_no_write", rd, 32'h10000002);

    // Back-to-back reads with req held: one ack every 5 cycles, in address order.
    @(negedge clk);
    req[1] = 1'b1; wr_en[1] = 1'b0; addr[1] = 8'h00;
    cyc = 0; last = -1; n = 0;
    while (n < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (ack[1]) begin
        chk($sformatf("b2b_rdata%0d", n), rdata[1], 32'h10000000 + n);
        if (n > 0) chk($sformatf("b2b_gap%0d", n), cyc - last, 32'd5);
        last = cyc;
        n++;
        if (n == 4) req[1] = 1'b0;
        else addr[1] = 8'(n);
      end
    end
    req[1] = 1'b0;
    chk("b2b_count", n, 32'd4);

    // Reset pulse during ACCESS abandons the write.
    @(negedge clk);
    req[1] = 1'b1; wr_en[1] = 1'b1; addr[1] = 8'h20; wdata[1] = 32'hCAFEF00D; byte_en[1] = 4'hF;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", {31'd0, busy[1]}, 32'd1);
    req[1] = 1'b0;
    rst_n[1] = 1'b0;
    #1;
    chk("mid_busy_drop", {31'd0, busy[1]}, 32'd0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack[1] || busy[1]) seen = 1'b1;
    end
    chk("mid_no_ack", {31'd0, seen}, 32'd0);
    do_op(1, 1'b0, 4'h0, 8'h20, 32'h0, rd, lat, bcyc);
    chk("mid_rdata", rd, 32'h00000000);
    chk("mid_latency", lat, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
